// File: rtl/my_module.sv
// my_module -- registered AND gate with an optional serial ID beacon.
//
// Logic mode: z is the registered AND of the synchronized x and y inputs.
//
// Beacon (compiled in only when MY_MODULE_ID_BEACON_EN is defined):
// a rising edge on the synchronized y with the synchronized x low, while
// idle, sends one frame on z. The frame is a start bit (1), then
// {id_num[7:0], version[3:0]} MSB first, then a stop bit (0). Each bit is
// held for BIT_CYCLES clocks, so a frame lasts 14*BIT_CYCLES clocks.
// Triggers that arrive during a frame are dropped. When the macro is
// undefined, z is always the logic-mode result and the parameters have no
// effect.
//
// Parameters:
//   id_num     8-bit instance identifier sent first in the frame
//   version    4-bit revision code sent after id_num
//   BIT_CYCLES clocks per frame bit, 1..255
//
// Ports (positional order x, y, z, clk, rst):
//   x   in  1  operand A / beacon qualifier (asynchronous to clk)
//   y   in  1  operand B / beacon trigger   (asynchronous to clk)
//   z   out 1  registered result or serial frame, driven from a flop
//   clk in  1  clock, rising edge
//   rst in  1  asynchronous active-high reset

module my_module #(
  parameter logic [7:0]  id_num     = 8'd0,
  parameter logic [3:0]  version    = 4'd1,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic x,
  input  logic y,
  output logic z,
  input  logic clk,
  input  logic rst
);

  // Two-flop synchronizers for the asynchronous inputs.
  logic x_m, x_s;
  logic y_m, y_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_m <= 1'b0;
      x_s <= 1'b0;
      y_m <= 1'b0;
      y_s <= 1'b0;
    end else begin
      x_m <= x;
      x_s <= x_m;
      y_m <= y;
      y_s <= y_m;
    end
  end

  logic logic_val;
  assign logic_val = x_s & y_s;

`ifdef MY_MODULE_ID_BEACON_EN

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [11:0] FRAME    = {id_num, version};
  localparam logic [7:0]  LAST_CYC = 8'(BIT_CYCLES - 1);
  localparam logic [3:0]  LAST_BIT = 4'd11;

  logic       y_d;
  logic [1:0] state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] cyc_cnt, cyc_cnt_nx;
  logic       z_nx;
  logic       trigger;
  logic       bit_done;
  logic [3:0] next_sel;

  // y_d follows y_s in every state, so an edge that lands mid-frame is
  // consumed there and cannot start a second frame afterwards.
  assign trigger  = y_s & ~y_d & ~x_s;
  assign bit_done = (cyc_cnt == LAST_CYC);
  // FRAME index of the bit that follows the current DATA bit.
  assign next_sel = 4'd10 - bit_cnt;

  // z_nx is the value z takes in the cycle after this edge, so every state
  // entry loads the first bit of the new state at the same edge.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    cyc_cnt_nx = cyc_cnt + 8'd1;
    z_nx       = z;
    case (state)
      IDLE: begin
        bit_cnt_nx = '0;
        cyc_cnt_nx = '0;
        if (trigger) begin
          state_nx = START;
          z_nx     = 1'b1;
        end else begin
          z_nx = logic_val;
        end
      end
      START: begin
        if (bit_done) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
          cyc_cnt_nx = '0;
          z_nx       = FRAME[LAST_BIT];
        end
      end
      DATA: begin
        if (bit_done) begin
          cyc_cnt_nx = '0;
          if (bit_cnt == LAST_BIT) begin
            state_nx   = STOP;
            bit_cnt_nx = '0;
            z_nx       = 1'b0;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
            z_nx       = FRAME[next_sel];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_nx   = IDLE;
          bit_cnt_nx = '0;
          cyc_cnt_nx = '0;
          z_nx       = logic_val;
        end
      end
      default: begin
        state_nx   = IDLE;
        bit_cnt_nx = '0;
        cyc_cnt_nx = '0;
        z_nx       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_d     <= 1'b0;
      state   <= IDLE;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      z       <= 1'b0;
    end else begin
      y_d     <= y_s;
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      cyc_cnt <= cyc_cnt_nx;
      z       <= z_nx;
    end
  end

`else

  // Parameters are accepted but carry no function in this build.
  logic unused_cfg;
  assign unused_cfg = ^{id_num, version, BIT_CYCLES};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z <= 1'b0;
    end else begin
      z <= logic_val;
    end
  end

`endif

endmodule

// File: tb/tb_my_module.sv
module tb_my_module;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x   = 1'b0;
  logic y   = 1'b0;
  logic z1, z2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [1:40] exp1, exp2;

  always #5 clk = ~clk;

  my_module #(.id_num(8'd1), .version(4'd1), .BIT_CYCLES(1)) dut1 (
    .x(x), .y(y), .z(z1), .clk(clk), .rst(rst)
  );

  my_module #(.id_num(8'd3), .version(4'd4), .BIT_CYCLES(2)) dut2 (
    .x(x), .y(y), .z(z2), .clk(clk), .rst(rst)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef MY_MODULE_ID_BEACON_EN
    // dut1: start at tick 3, id 00000001, version 0001, stop at tick 16.
    exp1 = 40'b0010_0000_0010_0010_0000_0000_0000_0000_0000_0000;
    // dut2: 2 clocks per bit, 1 / 00000011 / 0100 / 0 over ticks 3..30.
    exp2 = 40'b0011_0000_0000_0000_1111_0011_0000_0000_0000_0000;
`else
    exp1 = '0;
    exp2 = '0;
`endif

    // Reset with both inputs high.
    #1;
    rst = 1'b1;
    x   = 1'b1;
    y   = 1'b1;
    #1;
    check("rst_async_z1", z1, 1'b0);
    check("rst_async_z2", z2, 1'b0);
    tick();
    tick();
    check("rst_held_z1", z1, 1'b0);
    check("rst_held_z2", z2, 1'b0);

    // Release: x=y=1 reaches z after the third edge.
    rst = 1'b0;
    tick();
    check("rel_e1_z1", z1, 1'b0);
    tick();
    check("rel_e2_z1", z1, 1'b0);
    check("rel_e2_z2", z2, 1'b0);
    tick();
    check("rel_e3_z1", z1, 1'b1);
    check("rel_e3_z2", z2, 1'b1);

    // x=1, y toggles: z follows y three edges later, no frame.
    y = 1'b0;
    tick(); check("yfall_e1", z1, 1'b1);
    tick(); check("yfall_e2", z1, 1'b1);
    tick(); check("yfall_e3", z1, 1'b0);
    y = 1'b1;
    tick(); check("yrise_e1", z1, 1'b0);
    tick(); check("yrise_e2", z1, 1'b0);
    tick(); check("yrise_e3_z1", z1, 1'b1);
    check("yrise_e3_z2", z2, 1'b1);
    y = 1'b0;
    tick(); check("yfall2_e1", z1, 1'b1);
    tick(); check("yfall2_e2", z2, 1'b1);
    tick(); check("yfall2_e3_z1", z1, 1'b0);
    check("yfall2_e3_z2", z2, 1'b0);

    // Idle with x=0, y=0.
    x = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("idle_z1", z1, 1'b0);
    check("idle_z2", z2, 1'b0);

    // Beacon trigger plus a second pulse four cycles later.
    y = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) y = 1'b0;
      if (n == 4) y = 1'b1;
      if (n == 5) y = 1'b0;
      check($sformatf("frame_z1_t%0d", n), z1, exp1[n]);
      check($sformatf("frame_z2_t%0d", n), z2, exp2[n]);
    end

    // Reset in the middle of a frame.
    y = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      check($sformatf("abort_pre_z1_t%0d", n), z1, exp1[n]);
    end
    y   = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_async_z1", z1, 1'b0);
    check("abort_async_z2", z2, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      check($sformatf("abort_post_z1_t%0d", n), z1, 1'b0);
      check($sformatf("abort_post_z2_t%0d", n), z2, 1'b0);
    end

    // Asynchronous reset between edges while z is high.
    x = 1'b1;
    y = 1'b1;
    tick();
    tick();
    tick();
    check("pre_async_z1", z1, 1'b1);
    check("pre_async_z2", z2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_z1", z1, 1'b0);
    check("mid_async_z2", z2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
